uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial UART transmitter, 8N1 framing; directly upstream of the UART receiver stage.
- Accepts one byte per start/busy handshake from the parallel side.
- Serialises the byte onto `tx`, LSB first: start bit (0), 8 data bits, stop bit (1).
- `tx` connects to the receiver's `rx`; both blocks share the same clock and bit-period parameters.

Parameters:
- clk_value, 100_000: input clock frequency in Hz.
- baud, 9600: serial bit rate in bits/s.
- wait_count, clk_value / baud (integer division; default 10): clock cycles per serial bit. Must be >= 2; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to clk.
- tx_start  input  1  request to send `tx_data`; sampled every rising edge.
- tx_data  input  8  byte to transmit; captured only on an accepted request.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress; requests are ignored while high.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (rst_n = 0), asynchronous:
  - tx = 1, tx_busy = 0, tx_done = 0.
  - State = IDLE; bit counter = 0; bit index = 0; shift register = 0.
- Outputs: all registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - tx = 1, tx_busy = 0.
  - Accept when tx_start = 1 at a rising edge. On that edge: latch tx_data into the shift register, go to START, tx <= 0, tx_busy <= 1, counter <= 0.
  - tx_done is cleared on every edge where no frame completes.
- START: hold tx = 0 for wait_count cycles. When counter = wait_count-1: counter <= 0, go to DATA, tx <= shreg[0].
- DATA:
  - Each bit is held for wait_count cycles.
  - At counter = wait_count-1: shift right, index <= index+1, tx <= next bit.
  - After bit 7 completes: go to STOP, tx <= 1.
- STOP: hold tx = 1 for wait_count cycles. At counter = wait_count-1: go to IDLE, tx_busy <= 0, tx_done <= 1 for exactly one cycle.
- Latency and frame length:
  - tx falls on the same edge that accepts the request.
  - tx_busy is high for exactly 10*wait_count cycles per frame (11*wait_count with parity).
- Byte capture: tx_data changes after acceptance have no effect on the frame in flight.
- tx_start while tx_busy = 1: ignored, not queued, no error indication.
- tx_start held high continuously: a new frame begins on the edge after tx_done.
  - Minimum idle-high gap between frames = 1 cycle, so the effective stop bit is wait_count+1 cycles.
  - Back-to-back accept in the tx_done cycle is permitted.
- Reset mid-frame: frame aborted immediately; tx returns high asynchronously; no tx_done is produced.
- Counter widths: sized from wait_count; counter never exceeds wait_count-1. Bit index is 3 bits and wraps only via a state change.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity of the latched byte (XOR of its 8 bits), held wait_count cycles.
  - Frame = 11 bits; tx_busy high for 11*wait_count cycles.
- Undefined: no PARITY state; the 10-bit 8N1 frame exactly as above; no parity logic synthesised.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles with tx_start = 1 -> tx = 1, tx_busy = 0, tx_done = 0 throughout; no frame starts until after release.
- Single byte 0x55, defaults (wait_count = 10): pulse tx_start 1 cycle -> tx sequence 0,1,0,1,0,1,0,1,0,1, each 10 cycles; tx_busy high for exactly 100 cycles; tx_done pulses 1 cycle as tx_busy falls.
- Busy rejection: send 0xA3, pulse tx_start with tx_data = 0xFF at cycle 35 -> transmitted bits 1,1,0,0,0,1,0,1 (0xA3, LSB first); no second frame follows.
- Back-to-back: hold tx_start = 1 with tx_data = 0x0F, then 0xF0 -> two frames separated by exactly 1 idle-high cycle after the 10-cycle stop bit; two tx_done pulses 101 cycles apart.
- Reset mid-frame: assert rst_n = 0 at cycle 42 of a 0x81 frame -> tx = 1 and tx_busy = 0 immediately; no tx_done; next request after release produces a clean full frame.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit = 1 after bit 7, then stop bit; tx_busy high for 110 cycles. Send 0x03 -> parity bit = 0.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: parallel-side request/status bundle and serial line of the UART transmitter
interface uart_transmitter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  modport master (output tx_start, tx_data, input tx, tx_busy, tx_done);
  modport slave (input tx_start, tx_data, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART serialiser, LSB first, one byte per start/busy handshake
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter #(
  parameter int clk_value = 100_000,
  parameter int baud = 9600,
  parameter int wait_count = clk_value / baud
) (
  input logic clk,
  input logic rst_n,
  uart_transmitter_if.slave bus
);
  localparam int cw = $clog2(wait_count);
  localparam logic [cw-1:0] last = cw'(wait_count - 1);
  if (wait_count < 2) begin : g_bad_wait
    $error("uart_transmitter: wait_count must be >= 2");
  end
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q, par_n;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic tx_q, tx_n, busy_q, busy_n, done_q, done_n;
  logic wrap;
  assign wrap = cnt == last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      tx_q <= tx_n;
      busy_q <= busy_n;
      done_q <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q <= par_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n = wrap ? '0 : cnt + cw'(1);
    idx_n = idx;
    sh_n = sh;
    tx_n = tx_q;
    busy_n = busy_q;
    done_n = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n = par_q;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.tx_start) begin
          state_n = START;
          sh_n = bus.tx_data;
          tx_n = 1'b0;
          busy_n = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_n = ^bus.tx_data;
`endif
        end
      end
      START:
        if (wrap) begin
          state_n = DATA;
          idx_n = '0;
          tx_n = sh[0];
        end
      DATA:
        if (wrap) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n = par_q;
`else
            state_n = STOP;
            tx_n = 1'b1;
`endif
          end else begin
            sh_n = sh >> 1;
            idx_n = idx + 3'd1;
            tx_n = sh[1];
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (wrap) begin
          state_n = STOP;
          tx_n = 1'b1;
        end
`endif
      STOP:
        if (wrap) begin
          state_n = IDLE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  assign bus.tx = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed + randomized frames checked against a bit-timeline model of the UART frame
module tb_uart_transmitter;
  localparam int WC = 100_000 / 9600;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_transmitter_if bus();
  uart_transmitter #(.clk_value(100_000), .baud(9600)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_at = 0;
  int prev_done = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction
  task automatic idle_check(input int n);
    repeat (n) begin
      tick();
      check("idle", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
    end
  endtask
  // Returns just after the edge that raises tx_done; the frame timeline is bit k/WC of the frame word.
  task automatic run_frame(input logic [7:0] d, input bit hold, input int inj, input logic [7:0] inj_d, input logic [7:0] next_d);
    logic [10:0] fb;
    fb = frame_bits(d);
    bus.tx_data = d;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = hold;
    bus.tx_data = next_d;
    for (int k = 0; k < NB * WC; k++) begin
      if (k == inj) begin
        bus.tx_start = 1'b1;
        bus.tx_data = inj_d;
      end else if (k == inj + 1) bus.tx_start = hold;
      check("frame", {bus.tx, bus.tx_busy, bus.tx_done}, {fb[k / WC], 2'b10});
      tick();
    end
    check("done", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b101);
    prev_done = done_at;
    done_at = cyc;
  endtask
  initial begin
    bus.tx_start = 1'b1;
    bus.tx_data = 8'h55;
    repeat (5) begin
      tick();
      check("reset", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
    end
    rst_n = 1'b1;
    run_frame(8'h55, 1'b0, -1, 8'h00, 8'h00);
    idle_check(3);
    run_frame(8'hA3, 1'b0, 35, 8'hFF, 8'h00);
    idle_check(15);
    run_frame(8'($urandom), 1'b0, int'($urandom_range(1, 95)), 8'($urandom), 8'($urandom));
    idle_check(2);
    run_frame(8'h0F, 1'b1, -1, 8'h00, 8'hF0);
    run_frame(8'hF0, 1'b0, -1, 8'h00, 8'h00);
    check("b2b_gap", done_at - prev_done, NB * WC + 1);
    idle_check(3);
    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), 1'b0, -1, 8'h00, 8'($urandom));
      idle_check(int'($urandom_range(0, 3)));
    end
    bus.tx_data = 8'h81;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    bus.tx_data = 8'($urandom);
    repeat (42) tick();
    check("mid_bit", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b010);
    #2 rst_n = 1'b0;
    #1 check("abort", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
    repeat (3) begin
      tick();
      check("abort_hold", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
    end
    rst_n = 1'b1;
    idle_check(3);
    run_frame(8'h81, 1'b0, -1, 8'h00, 8'h00);
    idle_check(2);
    run_frame(8'h07, 1'b0, -1, 8'h00, 8'h00);
    idle_check(2);
    run_frame(8'h03, 1'b0, -1, 8'h00, 8'h00);
    idle_check(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
